uart_rx_loader: RTL and testbench



---
 rtl/uart_rx_loader.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_loader.sv
// Boot loader that parses a framed image from the UART byte stream (sync, length,
// little-endian 32-bit words, checksum) and writes the words into instruction/data memory.
module uart_rx_loader #(
  parameter int               ADDR_W    = 12,
  parameter logic [7:0]       SYNC_BYTE = 8'hA5,
  parameter int               TMO_W     = 24,
  parameter logic [TMO_W-1:0] TIMEOUT   = 24'd2083200
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        recv_data,
  input  logic              vald_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [15:0]       word_count
);

  localparam int          MAX_WORDS = 2 ** ADDR_W;
  localparam logic [16:0] MAX_N     = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_WAIT_SYNC = 3'd0,
    S_LEN_L     = 3'd1,
    S_LEN_H     = 3'd2,
    S_DATA      = 3'd3,
    S_CSUM      = 3'd4
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        sum_r, sum_s;
  logic [7:0]        len_l_r, len_l_s;
  logic [ADDR_W-1:0] word_idx_r, word_idx_s;
  logic [1:0]        byte_idx_r, byte_idx_s;
  logic [31:0]       asm_r, asm_s;
  logic [TMO_W-1:0]  tmo_r, tmo_s;
  logic              mem_we_s, busy_s, load_done_s, load_err_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0]       mem_wdata_s;
  logic [1:0]        err_code_s;
  logic [15:0]       word_count_s;
  logic [15:0]       n_s;
  logic              timeout_hit_s;

  // Next-state, datapath and registered-output logic for the frame parser.
  always_comb begin
    state_s      = state_r;
    sum_s        = sum_r;
    len_l_s      = len_l_r;
    word_idx_s   = word_idx_r;
    byte_idx_s   = byte_idx_r;
    asm_s        = asm_r;
    tmo_s        = tmo_r;
    mem_we_s     = 1'b0;
    load_done_s  = 1'b0;
    load_err_s   = 1'b0;
    mem_addr_s   = mem_addr;
    mem_wdata_s  = mem_wdata;
    busy_s       = busy;
    err_code_s   = err_code;
    word_count_s = word_count;
    n_s          = {recv_data, len_l_r};
    timeout_hit_s = busy && !vald_data && (tmo_r == (TIMEOUT - TMO_W'(1)));

    if (vald_data) begin
      tmo_s = '0;
    end else if (busy) begin
      tmo_s = tmo_r + TMO_W'(1);
    end else begin
      tmo_s = '0;
    end

    if (timeout_hit_s) begin
      state_s    = S_WAIT_SYNC;
      busy_s     = 1'b0;
      load_err_s = 1'b1;
      err_code_s = 2'b11;
      tmo_s      = '0;
    end else if (vald_data) begin
      case (state_r)
        S_WAIT_SYNC: begin
          if (recv_data == SYNC_BYTE) begin
            state_s    = S_LEN_L;
            busy_s     = 1'b1;
            err_code_s = 2'b00;
            sum_s      = 8'h00;
            word_idx_s = '0;
            byte_idx_s = 2'd0;
          end else begin
            state_s = S_WAIT_SYNC;
          end
        end
        S_LEN_L: begin
          len_l_s = recv_data;
          sum_s   = sum_r + recv_data;
          state_s = S_LEN_H;
        end
        S_LEN_H: begin
          sum_s        = sum_r + recv_data;
          word_count_s = n_s;
          if ({1'b0, n_s} > MAX_N) begin
            load_err_s = 1'b1;
            err_code_s = 2'b01;
            busy_s     = 1'b0;
            state_s    = S_WAIT_SYNC;
          end else if (n_s == 16'd0) begin
            state_s = S_CSUM;
          end else begin
            state_s = S_DATA;
          end
        end
        S_DATA: begin
          sum_s      = sum_r + recv_data;
          asm_s      = {recv_data, asm_r[31:8]};
          byte_idx_s = byte_idx_r + 2'd1;
          // Last byte of a word: bytes shift in from the top so byte 0 lands in [7:0].
          if (byte_idx_r == 2'd3) begin
            mem_we_s    = 1'b1;
            mem_addr_s  = word_idx_r;
            mem_wdata_s = {recv_data, asm_r[31:8]};
            word_idx_s  = word_idx_r + ADDR_W'(1);
            if (16'(word_idx_r) == (word_count - 16'd1)) begin
              state_s = S_CSUM;
            end else begin
              state_s = S_DATA;
            end
          end else begin
            state_s = S_DATA;
          end
        end
        S_CSUM: begin
          busy_s  = 1'b0;
          state_s = S_WAIT_SYNC;
          if (recv_data == sum_r) begin
            load_done_s = 1'b1;
          end else begin
            load_err_s = 1'b1;
            err_code_s = 2'b10;
          end
        end
        default: begin
          state_s = S_WAIT_SYNC;
          busy_s  = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r    <= S_WAIT_SYNC;
      sum_r      <= 8'h00;
      len_l_r    <= 8'h00;
      word_idx_r <= '0;
      byte_idx_r <= 2'd0;
      asm_r      <= 32'h0000_0000;
      tmo_r      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0000_0000;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      err_code   <= 2'b00;
      word_count <= 16'h0000;
    end else begin
      state_r    <= state_s;
      sum_r      <= sum_s;
      len_l_r    <= len_l_s;
      word_idx_r <= word_idx_s;
      byte_idx_r <= byte_idx_s;
      asm_r      <= asm_s;
      tmo_r      <= tmo_s;
      mem_we     <= mem_we_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
      busy       <= busy_s;
      load_done  <= load_done_s;
      load_err   <= load_err_s;
      err_code   <= err_code_s;
      word_count <= word_count_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: table of frames with expected writes/status,
// scoreboard queue of expected output events, plus timeout and mid-frame reset sequences.
module tb_uart_rx_loader;

  localparam int          ADDR_W = 12;
  localparam logic [23:0] TMO    = 24'd200;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        recv_data;
  logic              vald_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy, load_done, load_err;
  logic [1:0]        err_code;
  logic [15:0]       word_count;

  typedef struct {
    int          kind;   // 0 write, 1 done, 2 error
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    logic [127:0]     b;     // frame bytes, right-aligned, first byte most significant
    int               nb;
    int               gap;
    int               nw;
    logic [1:0][31:0] w;
    int               res;
    logic [1:0]       code;
    logic [15:0]      wc;
  } vec_t;

  ev_t  q[$];
  vec_t vecs[8];
  int   checks   = 0;
  int   failures = 0;

  uart_rx_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TMO_W(24), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(rst), .recv_data(recv_data), .vald_data(vald_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .load_done(load_done), .load_err(load_err), .err_code(err_code), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every pulse on mem_we/load_done/load_err must match the queue head.
  always @(negedge clk) begin
    if (!rst && (mem_we || load_done || load_err)) begin
      ev_t e;
      int  kind;
      kind = mem_we ? 0 : (load_done ? 1 : 2);
      checks++;
      if ((32'(mem_we) + 32'(load_done) + 32'(load_err)) != 32'd1) begin
        failures++;
        $display("FAIL pulse_exclusive we=%0b done=%0b err=%0b expected one", mem_we, load_done, load_err);
      end
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event kind=%0d addr=%h data=%h expected none", kind, mem_addr, mem_wdata);
      end else begin
        e = q.pop_front();
        if (kind != e.kind || (kind == 0 && (mem_addr != e.addr || mem_wdata != e.data))) begin
          failures++;
          $display("FAIL event kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                   kind, mem_addr, mem_wdata, e.kind, e.addr, e.data);
        end
      end
    end
  end

  task automatic send_bytes(input logic [127:0] b, input int nb, input int gap);
    for (int i = 0; i < nb; i++) begin
      recv_data = b[8*(nb-1-i) +: 8];
      vald_data = 1'b1;
      @(negedge clk);
      if (gap > 0) begin
        vald_data = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    vald_data = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic run_vec(input vec_t v, input string name);
    ev_t e;
    for (int i = 0; i < v.nw; i++) begin
      e.kind = 0; e.addr = 12'(i); e.data = v.w[i];
      q.push_back(e);
    end
    e.kind = v.res; e.addr = 12'h000; e.data = 32'h0;
    q.push_back(e);
    send_bytes(v.b, v.nb, v.gap);
    wait_drain(name, 50);
    repeat (2) @(negedge clk);
    chk({name, "_err_code"}, 32'(err_code), 32'(v.code));
    chk({name, "_word_count"}, 32'(word_count), 32'(v.wc));
    chk({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    ev_t e;
    vecs[0] = '{b: 128'(96'hA5020078563412EFBEADDE4E), nb: 12, gap: 0, nw: 2,
                w: {32'hDEADBEEF, 32'h12345678}, res: 1, code: 2'b00, wc: 16'd2};
    vecs[1] = vecs[0]; vecs[1].gap = 2;
    vecs[2] = vecs[0]; vecs[2].b = 128'(96'hA5020078563412EFBEADDE4F); vecs[2].res = 2; vecs[2].code = 2'b10;
    vecs[3] = '{b: 128'(32'hA5000000), nb: 4, gap: 1, nw: 0, w: {32'h0, 32'h0}, res: 1, code: 2'b00, wc: 16'd0};
    vecs[4] = '{b: 128'(24'hA50110), nb: 3, gap: 0, nw: 0, w: {32'h0, 32'h0}, res: 2, code: 2'b01, wc: 16'h1001};
    vecs[5] = vecs[0]; vecs[5].gap = 1;
    vecs[6] = vecs[0]; vecs[6].b = 128'(120'h00FF5AA5020078563412EFBEADDE4E); vecs[6].nb = 15;
    vecs[7] = '{b: 128'(64'hA50100A5A5A5A595), nb: 8, gap: 0, nw: 1,
                w: {32'h0, 32'hA5A5A5A5}, res: 1, code: 2'b00, wc: 16'd1};

    rst = 1'b1; vald_data = 1'b0; recv_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({load_done, load_err}), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Inter-byte timeout mid-word: error only, no write.
    e.kind = 2; e.addr = 12'h000; e.data = 32'h0;
    q.push_back(e);
    send_bytes(128'(8'hA5), 1, 0);
    chk("tmo_busy_after_sync", 32'(busy), 32'd1);
    send_bytes(128'(32'h02007856), 4, 0);
    wait_drain("tmo", int'(TMO) + 20);
    repeat (5) @(negedge clk);
    chk("tmo_err_code", 32'(err_code), 32'd3);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Reset after LEN_H: silent abort, then a clean load.
    send_bytes(128'(24'hA50200), 3, 0);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_word_count", 32'(word_count), 32'd0);
    chk("mid_rst_err_code", 32'(err_code), 32'd0);
    rst = 1'b0;
    repeat (int'(TMO) + 10) @(negedge clk);
    run_vec(vecs[0], "after_rst");

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
